axi_rd_engine: RTL
==================

Name: axi_rd_engine

Overview:
- AXI4 read master that is the responder for the prefetcher/Dcache read-request interface (rd_req/rd_type/rd_addr → ret_valid/ret_half/ret_data).
- Converts each accepted request into one or two AR bursts and assembles the R beats into a 256-bit return register.
- Sits between the data-side prefetcher and the AXI crossbar.
- Supports one outstanding request.

Parameters:
- ARID, 4'd1, constant ARID driven on every AR transfer.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rd_req  in  1  request valid
- rd_type  in  2  0 = single word (uncached), 1 = 16-byte line, 2 = 32-byte double line
- rd_addr  in  32  byte address; type 1/2 are 16-byte aligned
- rd_rdy  out  1  request accepted when rd_req && rd_rdy
- ret_valid  out  1  one-cycle pulse, request complete
- ret_half  out  1  one-cycle pulse, low 128 bits valid (type 2 only)
- ret_data  out  256  assembled data, word i at [32i+31:32i]
- arid  out  4; araddr  out  32; arlen  out  8; arsize  out  3; arburst  out  2; arvalid  out  1; arready  in  1
- rid  in  4; rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1

Behaviour:
- Reset: state IDLE; rd_rdy=1, arvalid=0, rready=0, ret_valid=0, ret_half=0, ret_data=0, beat counter=0.
- Handshake: rd_rdy is high only in IDLE. On acceptance, latch type and addr and clear beat counter.
- States: IDLE → AR → R → (AR2 → R2) → IDLE.
- AR: arvalid=1 from the cycle after acceptance until arready. arburst=INCR, arsize=3'd2. arid is always ARID.
- araddr/arlen per type:
  - type 0: araddr=rd_addr, arlen=0.
  - type 1: araddr=rd_addr, arlen=3.
  - type 2: araddr=rd_addr, arlen=7.
- Split: when type 2 and rd_addr[11:4]==8'hFF (the 32 bytes would cross a 4 KB boundary), AR issues arlen=3 at rd_addr, then AR2 issues arlen=3 at rd_addr+16.
- R/R2: rready=1. Each rvalid&&rready writes rdata into word slot = beat counter, then the counter increments (3-bit).
  - Type 0 writes slot 0; other slots are unchanged.
  - rresp and rid are ignored; data is taken as is.
- ret_half: pulsed the cycle after the 4th beat handshake, type 2 only (split or not). ret_data[127:0] is stable from that cycle on.
- R → IDLE on the rlast handshake, except split type 2 first burst: R → AR2.
- ret_valid: pulsed the cycle after the final rlast handshake (the cycle the state returns to IDLE). rd_rdy is also high that same cycle.
  - A new request may be accepted in the same cycle ret_valid pulses.
- ret_data holds its value until beats of the next request overwrite it.
- Minimum latency, type 1: accept at T, arvalid at T+1, arready at T+1, beats at T+2..T+5, ret_valid at T+6.
- rlast arriving early or late is honoured (rlast ends the burst). The beat counter saturates at 7; beats beyond slot 7 are dropped.
- rvalid seen outside R/R2 is ignored (rready=0).
- Reset mid-operation: immediate return to IDLE with reset values. The interconnect is reset with the block, so no orphan burst is tracked.
- rd_type=3 is treated as type 1.

Test Plan:
- Type 0, addr 0x1fc0_0004; slave returns rdata 0xDEAD_BEEF after 3 cycles → AR shows arlen=0, arsize=2; ret_valid one cycle after the beat; ret_data[31:0]=0xDEADBEEF; ret_half never asserted.
- Type 1, addr 0x0000_1230, arready immediate, beats 0x11,0x22,0x33,0x44 back-to-back → ret_valid at T+6; ret_data[127:0]=0x00000044_00000033_00000022_00000011.
- Type 2, addr 0x0000_2010, beats 1..8 with rvalid gaps → single AR with arlen=7; ret_half the cycle after beat 4 with [127:0] holding 4,3,2,1; ret_valid after beat 8 with [255:128] holding 8,7,6,5.
- Type 2, addr 0x0000_0FF0 → two ARs: 0x0FF0 arlen=3, then 0x1000 arlen=3; ret_half after the first rlast; ret_valid after the second; data ordered as in the previous case.
- Back-to-back requests: rd_req held with a second type 1 at 0x40 → accepted in the ret_valid cycle of the first; second arvalid on the next cycle; rd_rdy=0 while busy, so a request offered mid-burst stalls.
- reset asserted while in R after 2 beats → next cycle arvalid=0, rready=0, rd_rdy=1, ret_data=0; the following request completes normally.

Source files
------------

// File: rtl/axi_rd_engine_if.sv
// AXI4 read-address and read-data channels between the read engine and the crossbar.
interface axi_rd_engine_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_engine.sv
// Single-outstanding AXI4 read master serving prefetcher/Dcache word, line and double-line reads.
// Double lines that would cross a 4 KB page are issued as two 4-beat bursts.
module axi_rd_engine #(
    parameter logic [3:0] ARID = 4'd1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_req,
    input  logic [1:0]           rd_type,
    input  logic [31:0]          rd_addr,
    output logic                 rd_rdy,
    output logic                 ret_valid,
    output logic                 ret_half,
    output logic [255:0]         ret_data,
    axi_rd_engine_if.master      axi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AR2,
        S_R2
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        typ;
    logic [31:0]       addr;
    logic              split;
    logic [2:0]        cnt;
    logic              full;
    logic [7:0][31:0]  words;
    logic              ret_valid_q;
    logic              ret_half_q;

    logic              accept;
    logic              beat_hs;
    logic              last_burst;
    logic              rd_rdy_c;
    logic              arvalid_c;
    logic              rready_c;
    logic [31:0]       araddr_c;
    logic [7:0]        arlen_c;

    // ID and response code carry no information for a single-outstanding master.
    logic unused_r;
    assign unused_r = ^{axi.rid, axi.rresp};

    assign accept     = rd_req && rd_rdy_c;
    assign beat_hs    = axi.rvalid && rready_c;
    assign last_burst = (state == S_R2) || (state == S_R && !split);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (rd_req)                      state_nxt = S_AR;
            S_AR:   if (axi.arready)                 state_nxt = S_R;
            S_R:    if (beat_hs && axi.rlast)        state_nxt = split ? S_AR2 : S_IDLE;
            S_AR2:  if (axi.arready)                 state_nxt = S_R2;
            S_R2:   if (beat_hs && axi.rlast)        state_nxt = S_IDLE;
            default:                                 state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rd_rdy_c  = (state == S_IDLE);
        arvalid_c = (state == S_AR) || (state == S_AR2);
        rready_c  = (state == S_R)  || (state == S_R2);
        araddr_c  = (state == S_AR2) ? addr + 32'd16 : addr;
        if (typ == 2'd0)              arlen_c = 8'd0;
        else if (typ == 2'd2 && !split) arlen_c = 8'd7;
        else                          arlen_c = 8'd3;
    end

    // Request latch, beat counter and return assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            typ         <= 2'd0;
            addr        <= '0;
            split       <= 1'b0;
            cnt         <= 3'd0;
            full        <= 1'b0;
            words       <= '0;
            ret_valid_q <= 1'b0;
            ret_half_q  <= 1'b0;
        end else begin
            ret_valid_q <= beat_hs && axi.rlast && last_burst;
            ret_half_q  <= beat_hs && (typ == 2'd2) && (cnt == 3'd3) && !full;
            if (accept) begin
                typ   <= (rd_type == 2'd3) ? 2'd1 : rd_type;
                addr  <= rd_addr;
                split <= (rd_type == 2'd2) && (rd_addr[11:4] == 8'hFF);
                cnt   <= 3'd0;
                full  <= 1'b0;
            end else if (beat_hs && !full) begin
                // A word read only ever fills slot 0; stray extra beats are discarded.
                if (typ != 2'd0 || cnt == 3'd0)
                    words[cnt] <= axi.rdata;
                if (cnt == 3'd7) full <= 1'b1;
                else             cnt  <= cnt + 3'd1;
            end
        end
    end

    assign rd_rdy      = rd_rdy_c;
    assign ret_valid   = ret_valid_q;
    assign ret_half    = ret_half_q;
    assign ret_data    = words;

    assign axi.arid    = ARID;
    assign axi.araddr  = araddr_c;
    assign axi.arlen   = arlen_c;
    assign axi.arsize  = 3'd2;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_c;
    assign axi.rready  = rready_c;

endmodule
